// File: rtl/str_check_sequencer_pkg.sv
// Shared constants and types for the string-check sequencer: recognizer state codes,
// result codes and the controller state encoding.
package str_check_sequencer_pkg;

    localparam int REC_W  = 4;
    localparam int CODE_W = 2;

    localparam logic [REC_W-1:0] IDLE  = 4'd0;
    localparam logic [REC_W-1:0] START = 4'd1;
    localparam logic [REC_W-1:0] STOP  = 4'd2;
    localparam logic [REC_W-1:0] ERROR = 4'd3;

    localparam logic [CODE_W-1:0] RES_MATCH    = 2'd0;
    localparam logic [CODE_W-1:0] RES_MISMATCH = 2'd1;
    localparam logic [CODE_W-1:0] RES_TIMEOUT  = 2'd2;

    typedef enum logic [2:0] {
        C_WAIT,
        C_STEP,
        C_SETTLE,
        C_EVAL,
        C_REPORT,
        C_DRAIN
    } ctrl_state_t;

    // Both mismatches and timeouts feed the error statistic.
    function automatic logic res_is_error(input logic [CODE_W-1:0] code);
        return (code == RES_MISMATCH) || (code == RES_TIMEOUT);
    endfunction

endpackage

// File: rtl/str_check_sequencer_if.sv
// Signal bundle between the sequencer, its byte source, the recognizer and the result consumer.
interface str_check_sequencer_if
    import str_check_sequencer_pkg::*;
#(
    parameter int LEN_W = 8
) ();

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        rec_char;
    logic              rec_valid;
    logic              rec_error_verify;
    logic [REC_W-1:0]  rec_state;
    logic [REC_W-1:0]  rec_next_state;
    logic              res_valid;
    logic              res_ready;
    logic [CODE_W-1:0] res_code;
    logic [LEN_W-1:0]  res_len;
    logic [15:0]       match_cnt;
    logic [15:0]       err_cnt;
    logic              busy;

    modport master (
        input  in_data, in_valid, rec_next_state, res_ready,
        output in_ready, rec_char, rec_valid, rec_error_verify, rec_state,
               res_valid, res_code, res_len, match_cnt, err_cnt, busy
    );

    modport slave (
        output in_data, in_valid, rec_next_state, res_ready,
        input  in_ready, rec_char, rec_valid, rec_error_verify, rec_state,
               res_valid, res_code, res_len, match_cnt, err_cnt, busy
    );

endinterface

// File: rtl/str_check_sequencer_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module str_check_sequencer_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !(&cnt_q)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/str_check_sequencer.sv
// Byte-stream sequencer: steps the external string recognizer one character at a time
// and folds its STOP/ERROR outcomes into one result per 0x00-framed string.
module str_check_sequencer
    import str_check_sequencer_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 1000,
    parameter int TO_W    = 16
) (
    input logic                   clk,
    input logic                   rst,
    str_check_sequencer_if.master bus
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    ctrl_state_t       state_q;
    logic [7:0]        rec_char_q;
    logic              rec_valid_q;
    logic              rec_ev_q;
    logic [REC_W-1:0]  rec_state_q;
    logic              in_ready_q;
    logic              res_valid_q;
    logic [CODE_W-1:0] res_code_q;
    logic [LEN_W-1:0]  len_q;
    logic              err_flag_q;
    logic              in_str_q;
    logic              busy_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [TO_W-1:0]   to_cnt_d;

    logic        to_hit;
    logic        accept;
    logic        res_hs;
    logic        match_inc;
    logic        err_inc;
    logic [15:0] match_cnt;
    logic [15:0] err_cnt;

    function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + LEN_W'(1);
    endfunction

    always_comb begin
        to_hit    = (state_q == C_WAIT) && (to_cnt_q == TO_LIMIT);
        accept    = (state_q == C_WAIT) && !to_hit && bus.in_valid && in_ready_q;
        res_hs    = (state_q == C_REPORT) && res_valid_q && bus.res_ready;
        match_inc = res_hs && (res_code_q == RES_MATCH);
        err_inc   = res_hs && res_is_error(res_code_q);
        // Idle time only counts while parked mid-string waiting for the next byte.
        to_cnt_d  = to_cnt_q;
        if ((state_q != C_WAIT) || (rec_state_q == IDLE) || accept) begin
            to_cnt_d = '0;
        end else if (!to_hit) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= C_WAIT;
            rec_char_q  <= '0;
            rec_valid_q <= 1'b0;
            rec_ev_q    <= 1'b0;
            rec_state_q <= IDLE;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_code_q  <= RES_MATCH;
            len_q       <= '0;
            err_flag_q  <= 1'b0;
            in_str_q    <= 1'b0;
            busy_q      <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            rec_state_q <= bus.rec_next_state;
            rec_valid_q <= 1'b0;
            rec_ev_q    <= 1'b0;
            to_cnt_q    <= to_cnt_d;
            case (state_q)
                C_WAIT: begin
                    if (to_hit) begin
                        rec_ev_q    <= 1'b1;
                        res_code_q  <= RES_TIMEOUT;
                        res_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= C_REPORT;
                    end else if (accept) begin
                        rec_char_q  <= bus.in_data;
                        rec_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= C_STEP;
                    end else begin
                        // Drop ready one cycle early so the timeout edge never also takes a byte.
                        in_ready_q <= (to_cnt_d != TO_LIMIT);
                    end
                end
                C_STEP:   state_q <= C_SETTLE;
                C_SETTLE: state_q <= C_EVAL;
                C_EVAL: begin
                    if (in_str_q && (rec_char_q != 8'h00)) begin
                        len_q <= len_inc(len_q);
                    end
                    if ((rec_state_q == START) && (rec_char_q == 8'h00)) begin
                        len_q      <= '0;
                        err_flag_q <= 1'b0;
                        in_str_q   <= 1'b1;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= C_WAIT;
                    end else if ((rec_state_q == IDLE) && !err_flag_q && !in_str_q) begin
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= C_WAIT;
                    end else if (rec_state_q == STOP) begin
                        res_code_q  <= RES_MATCH;
                        res_valid_q <= 1'b1;
                        state_q     <= C_REPORT;
                    end else if ((rec_char_q == 8'h00) && ((rec_state_q == ERROR) || err_flag_q)) begin
                        res_code_q  <= RES_MISMATCH;
                        res_valid_q <= 1'b1;
                        rec_ev_q    <= (rec_state_q == ERROR);
                        state_q     <= C_REPORT;
                    end else begin
                        // A bad character poisons the string; keep consuming up to its 0x00.
                        if (rec_state_q == ERROR) begin
                            err_flag_q <= 1'b1;
                        end
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= C_WAIT;
                    end
                end
                C_REPORT: begin
                    if (res_hs) begin
                        res_valid_q <= 1'b0;
                        err_flag_q  <= 1'b0;
                        in_str_q    <= 1'b0;
                        state_q     <= C_DRAIN;
                    end
                end
                C_DRAIN: begin
                    if (rec_state_q == IDLE) begin
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= C_WAIT;
                    end
                end
                default: begin
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= C_WAIT;
                end
            endcase
        end
    end

    str_check_sequencer_sat_counter #(.W(16)) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (match_inc),
        .clr_i (1'b0),
        .q_o   (match_cnt)
    );

    str_check_sequencer_sat_counter #(.W(16)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (err_inc),
        .clr_i (1'b0),
        .q_o   (err_cnt)
    );

    assign bus.in_ready         = in_ready_q;
    assign bus.rec_char         = rec_char_q;
    assign bus.rec_valid        = rec_valid_q;
    assign bus.rec_error_verify = rec_ev_q;
    assign bus.rec_state        = rec_state_q;
    assign bus.res_valid        = res_valid_q;
    assign bus.res_code         = res_code_q;
    assign bus.res_len          = len_q;
    assign bus.match_cnt        = match_cnt;
    assign bus.err_cnt          = err_cnt;
    assign bus.busy             = busy_q;

endmodule

// File: tb/tb_str_check_sequencer.sv
// Bench for str_check_sequencer with a behavioural recognizer for strings 00 '$' digits '+' letters 00.
module tb_str_check_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    str_check_sequencer_if #(.LEN_W(8)) bus ();

    str_check_sequencer #(.LEN_W(8), .TIMEOUT(8), .TO_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int code;
        int len;
        int mcnt;
        int ecnt;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    int         checks   = 0;
    int         failures = 0;
    int         rv_cnt   = 0;
    int         ev_cnt   = 0;
    int         rv0, ev0;
    logic       pend     = 1'b0;
    int         pm       = 0;
    int         pe       = 0;
    logic [7:0] msg[$];
    logic [3:0] model_next;

    function automatic logic is_dig(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_alpha(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

    function automatic logic [3:0] rec_f(input logic [3:0] s, input logic [7:0] c);
        case (s)
            4'd0:    return (c == 8'h00) ? 4'd1 : 4'd0;
            4'd1:    return (c == 8'h24) ? 4'd4 : 4'd3;
            4'd4:    return is_dig(c) ? 4'd5 : 4'd3;
            4'd5:    return is_dig(c) ? 4'd5 : ((c == 8'h2B) ? 4'd6 : 4'd3);
            4'd6:    return is_alpha(c) ? 4'd7 : 4'd3;
            4'd7:    return is_alpha(c) ? 4'd7 : ((c == 8'h00) ? 4'd2 : 4'd3);
            4'd3:    return (c == 8'h00) ? 4'd0 : 4'd3;
            default: return 4'd0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            model_next <= 4'd0;
        end else if (bus.rec_error_verify) begin
            model_next <= 4'd0;
        end else if (bus.rec_state == 4'd2) begin
            model_next <= 4'd0;
        end else if (bus.rec_valid) begin
            model_next <= rec_f(bus.rec_state, bus.rec_char);
        end
    end
    assign bus.rec_next_state = model_next;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rec_valid) rv_cnt++;
        if (bus.rec_error_verify) ev_cnt++;
    end

    // Scoreboard monitor: pops one expectation per result handshake.
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                check("match_cnt", int'(bus.match_cnt), pm);
                check("err_cnt", int'(bus.err_cnt), pe);
                pend = 1'b0;
            end
            if (bus.res_valid && bus.res_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result code=%0d len=%0d required=none",
                             bus.res_code, bus.res_len);
                end else begin
                    cur = sb.pop_front();
                    check("res_code", int'(bus.res_code), cur.code);
                    check("res_len", int'(bus.res_len), cur.len);
                    pm   = cur.mcnt;
                    pe   = cur.ecnt;
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic push_exp(input int code, input int len, input int m, input int e);
        exp_t x;
        x.code = code;
        x.len  = len;
        x.mcnt = m;
        x.ecnt = e;
        sb.push_back(x);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL in_ready_wait actual=0 required=1 byte=%02h", b);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
        end
    endtask

    task automatic send_msg();
        foreach (msg[i]) send_byte(msg[i]);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 400) begin
            failures++;
            $display("FAIL %s_done pending=%0d busy=%0d required=0/0", name, sb.size(), bus.busy);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_res_valid", int'(bus.res_valid), 0);
        check("rst_rec_state", int'(bus.rec_state), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(bus.in_ready), 1);

        // Matching string with latency check
        push_exp(0, 7, 1, 0);
        msg = '{8'h00, "$", "1", "2", "3", "+", "A", "B", 8'h00};
        send_msg();
        repeat (3) @(negedge clk);
        check("lat_before_t3", int'(bus.res_valid), 0);
        @(negedge clk);
        check("lat_at_t3", int'(bus.res_valid), 1);
        wait_done("match");

        // Bad character, recognizer leaves ERROR on the terminator
        push_exp(1, 3, 1, 1);
        rv0 = rv_cnt;
        ev0 = ev_cnt;
        msg = '{8'h00, "$", "x", "y", 8'h00};
        send_msg();
        wait_done("mismatch");
        check("rec_valid_pulses", rv_cnt - rv0, 5);
        check("ev_pulses_mismatch", ev_cnt - ev0, 0);

        // Empty string: second 00 drives START->ERROR
        push_exp(1, 0, 1, 2);
        ev0 = ev_cnt;
        msg = '{8'h00, 8'h00};
        send_msg();
        wait_done("double_zero");
        check("ev_pulses_double_zero", ev_cnt - ev0, 1);
        check("rec_state_idle", int'(bus.rec_state), 0);

        // Timeout mid-string, then a fresh string
        push_exp(2, 2, 1, 3);
        ev0 = ev_cnt;
        msg = '{8'h00, "$", "1"};
        send_msg();
        wait_done("timeout");
        check("ev_pulses_timeout", ev_cnt - ev0, 1);
        push_exp(0, 4, 2, 3);
        msg = '{8'h00, "$", "7", "+", "K", 8'h00};
        send_msg();
        wait_done("after_timeout");

        // Consumer back-pressure on a MATCH
        push_exp(0, 4, 3, 3);
        msg = '{8'h00, "$", "9", "+", "Z"};
        send_msg();
        bus.res_ready = 1'b0;
        send_byte(8'h00);
        begin
            int n = 0;
            while (!bus.res_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("stall_res_valid_seen", int'(bus.res_valid), 1);
        end
        for (int i = 0; i < 20; i++) begin
            check("stall_res_valid", int'(bus.res_valid), 1);
            check("stall_res_code", int'(bus.res_code), 0);
            check("stall_res_len", int'(bus.res_len), 4);
            check("stall_in_ready", int'(bus.in_ready), 0);
            check("stall_match_cnt", int'(bus.match_cnt), 2);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        wait_done("stall");

        // Asynchronous reset between edges, mid-string
        msg = '{8'h00, "$", "1"};
        send_msg();
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready", int'(bus.in_ready), 0);
        check("arst_rec_valid", int'(bus.rec_valid), 0);
        check("arst_rec_char", int'(bus.rec_char), 0);
        check("arst_rec_ev", int'(bus.rec_error_verify), 0);
        check("arst_rec_state", int'(bus.rec_state), 0);
        check("arst_res_valid", int'(bus.res_valid), 0);
        check("arst_res_code", int'(bus.res_code), 0);
        check("arst_res_len", int'(bus.res_len), 0);
        check("arst_match_cnt", int'(bus.match_cnt), 0);
        check("arst_err_cnt", int'(bus.err_cnt), 0);
        check("arst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_exp(0, 4, 1, 0);
        msg = '{8'h00, "$", "5", "+", "Q", 8'h00};
        send_msg();
        wait_done("after_reset");

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
